rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
// In-order completion tracker: the receiving end of the CDB broadcast.
// - Allocates one entry per dispatched instruction and returns its Tag.
// - Snoops cdb_packet and marks the entry named by cdb_packet.Tag done, latching Value and take_branch.
// - Retires done entries in program order, at most one per cycle, driving the architectural regfile write port.
// - Flushes all entries when a retiring instruction took a branch.
// PARAMETERS
// ROB_SZ  8                 number of entries; power of two, >= 2
// TAG_W   $clog2(ROB_SZ)    entry index width; uses the low TAG_W bits of cdb_packet.Tag
// PORTS
// clock              in   1       system clock; all state updates on posedge
// reset              in   1       synchronous, active-high
// dispatch_valid     in   1       allocate an entry this cycle
// dispatch_dest_idx  in   5       architectural destination register
// dispatch_pc        in   XLEN    PC of the dispatched instruction
// dispatch_ready     out  1       !full; combinational from registered count
// dispatch_tag       out  TAG_W   tail index; the Tag assigned on a successful dispatch
// cdb_packet         in   CDB_PACKET  completion broadcast (uses valid, Tag, Value, take_branch)
// wb_regfile_en      out  1       registered; regfile write enable
// wb_regfile_idx     out  5       registered; regfile write index
// wb_regfile_data    out  XLEN    registered; regfile write data
// retire_valid       out  1       registered; one instruction retired
// retire_pc          out  XLEN    registered; PC of the retired instruction
// squash             out  1       registered; one-cycle pulse, retired instruction took a branch
// rob_count          out  TAG_W+1 registered occupancy, 0..ROB_SZ
// BEHAVIOUR
// - Reset: head=tail=0, count=0; every entry valid=0 and done=0.
//   All registered outputs are 0. dispatch_ready=1, dispatch_tag=0.
// - Dispatch fires when dispatch_valid && dispatch_ready && !squash.
//   - Writes entry[tail] = {valid=1, done=0, dest, pc}.
//   - tail <= tail+1, wrapping mod ROB_SZ.
// - CDB: when cdb_packet.valid and entry[Tag].valid, set done=1 and latch Value and take_branch.
//   - A CDB hit on an invalid entry is ignored.
//   - A duplicate CDB to an already-done entry overwrites Value.
// - Retire fires when entry[head].valid && entry[head].done && !squash.
//   - Clears the entry; head <= head+1, wrapping.
//   - Next cycle: retire_valid=1, retire_pc=pc, wb_regfile_idx=dest, wb_regfile_data=Value.
//   - wb_regfile_en=1 only when dest != ZERO_REG.
//   - If take_branch=1, squash=1 in that same next cycle.
//   - Any cycle without a retire: retire_valid, wb_regfile_en and squash are 0; idx/data/pc hold their last values.
// - Latency:
//   - CDB done in cycle N -> done visible N+1 -> retire decision N+1 -> regfile write visible N+2.
//   - There is no same-cycle bypass from CDB to retire.
// - Squash cycle:
//   - All entries are invalidated; head=tail=count=0.
//   - Dispatch and CDB inputs are ignored for that cycle.
//   - The flush takes effect at the end of the squash cycle.
// - Count update: count += dispatch_fire - retire_fire.
//   - Simultaneous dispatch and retire leaves count unchanged.
//   - When full, dispatch_ready=0 even if a retire happens the same cycle (no bypass).
// - Wrap: head/tail are TAG_W-bit indices; full/empty are resolved by count, never by pointer equality.
// - Reset mid-operation overrides dispatch, CDB and retire in that cycle.
// TESTING
// 1. Reset, dispatch dest=x5 pc=0x100 (tag 0), CDB Tag=0 Value=0x2A
//    -> two cycles later wb_regfile_en=1, idx=5, data=0x2A, retire_pc=0x100.
// 2. Dispatch tags 0,1,2; CDB in order 2,0,1
//    -> retires occur in order 0,1,2 on consecutive cycles, never 2 first.
// 3. Dispatch 8 entries with ROB_SZ=8
//    -> dispatch_ready=0, rob_count=8. Retire one
//    -> ready returns to 1, next dispatch_tag=0 (wrap).
// 4. Dispatch tags 0..3; CDB Tag=0 take_branch=1
//    -> retire of tag 0 with squash=1; next cycle rob_count=0, dispatch_tag=0, later CDB Tag=1 ignored.
// 5. dispatch dest=x0, complete it
//    -> retire_valid=1 with wb_regfile_en=0.
// 6. Assert reset while 3 entries are pending and a CDB is valid
//    -> next cycle all outputs 0, rob_count=0, no retire.

Source files
------------

// File: rtl/rob_retire_if.sv
// Shared types and the dispatch / CDB / retire signal bundle for rob_retire.
// The DUT connects through the slave modport; the driving side uses master.
package rob_retire_pkg;
  localparam int XLEN = 32;
  localparam int CDB_TAG_W = 6;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] Tag;
    logic [XLEN-1:0]      Value;
    logic                 take_branch;
  } cdb_packet_t;
endpackage

interface rob_retire_if #(parameter int ROB_SZ = 8);
  import rob_retire_pkg::*;
  localparam int TAG_W = $clog2(ROB_SZ);

  logic              dispatch_valid;
  logic [4:0]        dispatch_dest_idx;
  logic [XLEN-1:0]   dispatch_pc;
  logic              dispatch_ready;
  logic [TAG_W-1:0]  dispatch_tag;
  cdb_packet_t       cdb_packet;
  logic              wb_regfile_en;
  logic [4:0]        wb_regfile_idx;
  logic [XLEN-1:0]   wb_regfile_data;
  logic              retire_valid;
  logic [XLEN-1:0]   retire_pc;
  logic              squash;
  logic [TAG_W:0]    rob_count;

  modport master (
    output dispatch_valid, dispatch_dest_idx, dispatch_pc, cdb_packet,
    input  dispatch_ready, dispatch_tag, wb_regfile_en, wb_regfile_idx,
           wb_regfile_data, retire_valid, retire_pc, squash, rob_count
  );

  modport slave (
    input  dispatch_valid, dispatch_dest_idx, dispatch_pc, cdb_packet,
    output dispatch_ready, dispatch_tag, wb_regfile_en, wb_regfile_idx,
           wb_regfile_data, retire_valid, retire_pc, squash, rob_count
  );
endinterface

// File: rtl/rob_retire.sv
// In-order completion tracker: allocates entries at dispatch, marks them done
// from the CDB, retires in program order and flushes on a taken branch.
module rob_retire #(
  parameter int ROB_SZ = 8
) (
  input logic        clock,
  input logic        reset,
  rob_retire_if.slave rif
);
  import rob_retire_pkg::*;
  localparam int TAG_W = $clog2(ROB_SZ);

  logic [ROB_SZ-1:0] valid_q;
  logic [ROB_SZ-1:0] done_q;
  logic [ROB_SZ-1:0] br_q;
  logic [4:0]        dest_q  [ROB_SZ];
  logic [XLEN-1:0]   pc_q    [ROB_SZ];
  logic [XLEN-1:0]   value_q [ROB_SZ];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              wb_en_q;
  logic [4:0]        wb_idx_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              ret_valid_q;
  logic [XLEN-1:0]   ret_pc_q;
  logic              squash_q;

  logic              dispatch_fire;
  logic              retire_fire;
  logic              cdb_hit;
  logic [TAG_W-1:0]  cdb_tag;
  logic              unused_tag_hi;

  assign rif.dispatch_ready  = (count_q != (TAG_W+1)'(ROB_SZ));
  assign rif.dispatch_tag    = tail_q;
  assign rif.wb_regfile_en   = wb_en_q;
  assign rif.wb_regfile_idx  = wb_idx_q;
  assign rif.wb_regfile_data = wb_data_q;
  assign rif.retire_valid    = ret_valid_q;
  assign rif.retire_pc       = ret_pc_q;
  assign rif.squash          = squash_q;
  assign rif.rob_count       = count_q;
  assign unused_tag_hi       = ^rif.cdb_packet.Tag[CDB_TAG_W-1:TAG_W];

  // Fire conditions and pointer/occupancy next state; squash_q blocks all activity.
  always_comb begin
    cdb_tag       = rif.cdb_packet.Tag[TAG_W-1:0];
    dispatch_fire = rif.dispatch_valid && rif.dispatch_ready && !squash_q;
    cdb_hit       = rif.cdb_packet.valid && valid_q[cdb_tag] && !squash_q;
    retire_fire   = valid_q[head_q] && done_q[head_q] && !squash_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (squash_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (dispatch_fire) begin
        tail_d = tail_q + TAG_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (retire_fire) begin
        head_d = head_q + TAG_W'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + (TAG_W+1)'(dispatch_fire) - (TAG_W+1)'(retire_fire);
    end
  end

  // Control state and registered retire outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= 5'd0;
      wb_data_q   <= '0;
      ret_valid_q <= 1'b0;
      ret_pc_q    <= '0;
      squash_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (squash_q) begin
        valid_q <= '0;
        done_q  <= '0;
      end else begin
        if (dispatch_fire) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
        end
        if (cdb_hit) begin
          done_q[cdb_tag] <= 1'b1;
        end
        // Retire clear is last so it wins over a duplicate CDB to the head.
        if (retire_fire) begin
          valid_q[head_q] <= 1'b0;
          done_q[head_q]  <= 1'b0;
        end
      end
      ret_valid_q <= retire_fire;
      wb_en_q     <= retire_fire && (dest_q[head_q] != ZERO_REG);
      squash_q    <= retire_fire && br_q[head_q];
      if (retire_fire) begin
        wb_idx_q  <= dest_q[head_q];
        wb_data_q <= value_q[head_q];
        ret_pc_q  <= pc_q[head_q];
      end else begin
        wb_idx_q  <= wb_idx_q;
        wb_data_q <= wb_data_q;
        ret_pc_q  <= ret_pc_q;
      end
    end
  end

  // Entry payload; only read behind valid/done, so it needs no reset.
  always_ff @(posedge clock) begin
    if (!reset && !squash_q) begin
      if (dispatch_fire) begin
        dest_q[tail_q] <= rif.dispatch_dest_idx;
        pc_q[tail_q]   <= rif.dispatch_pc;
      end
      if (cdb_hit) begin
        value_q[cdb_tag] <= rif.cdb_packet.Value;
        br_q[cdb_tag]    <= rif.cdb_packet.take_branch;
      end
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a vector table for the basic in-order flow,
// then hand-written sequences for full/wrap, branch squash and mid-run reset.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  rob_retire_if #(.ROB_SZ(8)) rif ();
  rob_retire #(.ROB_SZ(8)) dut (.clock(clock), .reset(reset), .rif(rif));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        dv;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        cv;
    logic [5:0]  ctag;
    logic [31:0] cval;
    logic        cbr;
    logic        e_ready;
    logic [2:0]  e_tag;
    logic [3:0]  e_count;
    logic        e_rv;
    logic        e_en;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic        e_sq;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic dv, input logic [4:0] dest, input logic [31:0] pc,
                     input logic cv, input logic [5:0] ctag, input logic [31:0] cval,
                     input logic cbr);
    rif.dispatch_valid          = dv;
    rif.dispatch_dest_idx       = dest;
    rif.dispatch_pc             = pc;
    rif.cdb_packet.valid        = cv;
    rif.cdb_packet.Tag          = ctag;
    rif.cdb_packet.Value        = cval;
    rif.cdb_packet.take_branch  = cbr;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    // dv dest pc | cv ctag cval cbr | ready tag count | rv en idx data pc sq
    vecs[0]  = '{1'b1, 5'd5, 32'h100, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd0, 32'h2A, 1'b0, 1'b1, 3'd1, 4'd1, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0,   1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,   1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd1, 4'd0, 1'b1, 1'b1, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[3]  = '{1'b1, 5'd1, 32'h200, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd2, 4'd1, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[4]  = '{1'b1, 5'd2, 32'h204, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd3, 4'd2, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[5]  = '{1'b1, 5'd3, 32'h208, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd4, 4'd3, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd3, 32'h33, 1'b0, 1'b1, 3'd4, 4'd3, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd1, 32'h11, 1'b0, 1'b1, 3'd4, 4'd3, 1'b0, 1'b0, 5'd5, 32'h2A, 32'h100, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd2, 32'h22, 1'b0, 1'b1, 3'd4, 4'd2, 1'b1, 1'b1, 5'd1, 32'h11, 32'h200, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,   1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd4, 4'd1, 1'b1, 1'b1, 5'd2, 32'h22, 32'h204, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,   1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd4, 4'd0, 1'b1, 1'b1, 5'd3, 32'h33, 32'h208, 1'b0};
    vecs[11] = '{1'b1, 5'd0, 32'h300, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd5, 4'd1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h208, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd4, 32'h55, 1'b0, 1'b1, 3'd5, 4'd1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h208, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,   1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd5, 4'd0, 1'b1, 1'b0, 5'd0, 32'h55, 32'h300, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,   1'b1, 6'd5, 32'h99, 1'b0, 1'b1, 3'd5, 4'd0, 1'b0, 1'b0, 5'd0, 32'h55, 32'h300, 1'b0};
    vecs[15] = '{1'b0, 5'd0, 32'h0,   1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 3'd5, 4'd0, 1'b0, 1'b0, 5'd0, 32'h55, 32'h300, 1'b0};

    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_ready", 64'(rif.dispatch_ready), 64'd1);
    chk("reset_tag",   64'(rif.dispatch_tag),   64'd0);
    chk("reset_count", 64'(rif.rob_count),      64'd0);
    chk("reset_rv",    64'(rif.retire_valid),   64'd0);
    chk("reset_en",    64'(rif.wb_regfile_en),  64'd0);
    chk("reset_sq",    64'(rif.squash),         64'd0);
    chk("reset_data",  64'(rif.wb_regfile_data), 64'd0);

    // Basic flow, out-of-order completion, x0 destination, CDB to invalid entry
    for (int i = 0; i < 16; i++) begin
      drv(vecs[i].dv, vecs[i].dest, vecs[i].pc, vecs[i].cv, vecs[i].ctag, vecs[i].cval, vecs[i].cbr);
      cyc();
      chk($sformatf("v%0d_ready", i), 64'(rif.dispatch_ready),  64'(vecs[i].e_ready));
      chk($sformatf("v%0d_tag", i),   64'(rif.dispatch_tag),    64'(vecs[i].e_tag));
      chk($sformatf("v%0d_count", i), 64'(rif.rob_count),       64'(vecs[i].e_count));
      chk($sformatf("v%0d_rv", i),    64'(rif.retire_valid),    64'(vecs[i].e_rv));
      chk($sformatf("v%0d_en", i),    64'(rif.wb_regfile_en),   64'(vecs[i].e_en));
      chk($sformatf("v%0d_idx", i),   64'(rif.wb_regfile_idx),  64'(vecs[i].e_idx));
      chk($sformatf("v%0d_data", i),  64'(rif.wb_regfile_data), 64'(vecs[i].e_data));
      chk($sformatf("v%0d_pc", i),    64'(rif.retire_pc),       64'(vecs[i].e_pc));
      chk($sformatf("v%0d_sq", i),    64'(rif.squash),          64'(vecs[i].e_sq));
    end

    // Fill to full, no dispatch bypass on retire, tail wraps to 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 5'(i + 1), 32'h400 + 32'(4 * i), 1'b0, 6'd0, 32'h0, 1'b0);
      cyc();
    end
    chk("full_ready", 64'(rif.dispatch_ready), 64'd0);
    chk("full_count", 64'(rif.rob_count),      64'd8);
    chk("full_tag",   64'(rif.dispatch_tag),   64'd0);
    drv(1'b1, 5'd9, 32'h4F0, 1'b1, 6'd0, 32'h77, 1'b0);
    cyc();
    chk("full_blocked_count", 64'(rif.rob_count), 64'd8);
    drv(1'b1, 5'd9, 32'h4F0, 1'b0, 6'd0, 32'h0, 1'b0);
    cyc();
    chk("full_ret_count", 64'(rif.rob_count),       64'd7);
    chk("full_ret_ready", 64'(rif.dispatch_ready),  64'd1);
    chk("full_ret_tag",   64'(rif.dispatch_tag),    64'd0);
    chk("full_ret_rv",    64'(rif.retire_valid),    64'd1);
    chk("full_ret_pc",    64'(rif.retire_pc),       64'h400);
    chk("full_ret_data",  64'(rif.wb_regfile_data), 64'h77);
    cyc();
    chk("wrap_count", 64'(rif.rob_count),      64'd8);
    chk("wrap_ready", 64'(rif.dispatch_ready), 64'd0);
    chk("wrap_tag",   64'(rif.dispatch_tag),   64'd1);

    // Taken branch at head flushes everything; inputs ignored in squash cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 5'(10 + i), 32'h600 + 32'(4 * i), 1'b0, 6'd0, 32'h0, 1'b0);
      cyc();
    end
    drv(1'b0, 5'd0, 32'h0, 1'b1, 6'd0, 32'hAB, 1'b1);
    cyc();
    idle();
    cyc();
    chk("br_rv",    64'(rif.retire_valid),    64'd1);
    chk("br_sq",    64'(rif.squash),          64'd1);
    chk("br_en",    64'(rif.wb_regfile_en),   64'd1);
    chk("br_idx",   64'(rif.wb_regfile_idx),  64'd10);
    chk("br_data",  64'(rif.wb_regfile_data), 64'hAB);
    chk("br_count", 64'(rif.rob_count),       64'd3);
    drv(1'b1, 5'd20, 32'h700, 1'b1, 6'd1, 32'hCD, 1'b0);
    cyc();
    chk("post_sq",    64'(rif.squash),         64'd0);
    chk("post_rv",    64'(rif.retire_valid),   64'd0);
    chk("post_count", 64'(rif.rob_count),      64'd0);
    chk("post_tag",   64'(rif.dispatch_tag),   64'd0);
    chk("post_ready", 64'(rif.dispatch_ready), 64'd1);
    drv(1'b0, 5'd0, 32'h0, 1'b1, 6'd1, 32'hEE, 1'b0);
    cyc();
    idle();
    cyc();
    chk("post_cdb_rv",    64'(rif.retire_valid), 64'd0);
    chk("post_cdb_count", 64'(rif.rob_count),    64'd0);

    // Reset mid-operation with pending entries and a live CDB
    do_reset();
    drv(1'b1, 5'd7, 32'h500, 1'b0, 6'd0, 32'h0, 1'b0);
    cyc();
    drv(1'b0, 5'd0, 32'h0, 1'b1, 6'd0, 32'h5A, 1'b0);
    cyc();
    idle();
    cyc();
    chk("pre_rst_rv",   64'(rif.retire_valid),    64'd1);
    chk("pre_rst_data", 64'(rif.wb_regfile_data), 64'h5A);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'(i + 1), 32'h510 + 32'(4 * i), 1'b0, 6'd0, 32'h0, 1'b0);
      cyc();
    end
    chk("pre_rst_count", 64'(rif.rob_count), 64'd3);
    reset = 1'b1;
    drv(1'b1, 5'd8, 32'h800, 1'b1, 6'd1, 32'h66, 1'b0);
    cyc();
    reset = 1'b0;
    chk("rst_count", 64'(rif.rob_count),       64'd0);
    chk("rst_tag",   64'(rif.dispatch_tag),    64'd0);
    chk("rst_ready", 64'(rif.dispatch_ready),  64'd1);
    chk("rst_rv",    64'(rif.retire_valid),    64'd0);
    chk("rst_en",    64'(rif.wb_regfile_en),   64'd0);
    chk("rst_idx",   64'(rif.wb_regfile_idx),  64'd0);
    chk("rst_data",  64'(rif.wb_regfile_data), 64'd0);
    chk("rst_pc",    64'(rif.retire_pc),       64'd0);
    chk("rst_sq",    64'(rif.squash),          64'd0);
    idle();
    cyc();
    chk("rst_after_rv",    64'(rif.retire_valid), 64'd0);
    chk("rst_after_count", 64'(rif.rob_count),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
